// File: rtl/otter_lsu_split.sv
// Splits word-crossing loads (two aligned reads, merged) and stores (byte writes) for OTTER data port 2.
// Pass-through: 0 extra cycles. Split load: 3 cycles. Split store: n cycles. STALL holds the MEM stage during a split.
module otter_lsu_split #(
   parameter logic [31:0] IO_BASE = 32'h11000000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [31:0] REQ_WDATA,
   input  logic [1:0]  REQ_SIZE,
   input  logic        REQ_SIGN,
   output logic        STALL,
   output logic        RSP_VALID,
   output logic [31:0] RSP_DATA,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_READ2,
   output logic        MEM_WRITE2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   typedef enum logic [1:0] {IDLE, LD_HI, LD_FIN, ST_BYTE} state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pend_q, pend_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        word_q, word_d;
   logic        sign_q, sign_d;
   logic [31:0] lo_q, lo_d;

   logic        req_live;
   logic        crossing;
   logic [63:0] window;
   logic [31:0] win_sh;
   logic [7:0]  st_byte;
   logic [1:0]  last_cnt;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         pend_q  <= 1'b0;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         word_q  <= 1'b0;
         sign_q  <= 1'b0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         word_q  <= word_d;
         sign_q  <= sign_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      pend_d     = 1'b0;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      word_d     = word_q;
      sign_d     = sign_q;
      lo_d       = lo_q;
      STALL      = 1'b0;
      MEM_ADDR2  = 32'd0;
      MEM_DIN2   = 32'd0;
      MEM_READ2  = 1'b0;
      MEM_WRITE2 = 1'b0;
      MEM_SIZE   = 2'd0;
      MEM_SIGN   = 1'b0;

      req_live = REQ_VALID && (REQ_SIZE != 2'd3);
      crossing = ((REQ_SIZE == 2'd1 && REQ_ADDR[1:0] == 2'd3) ||
                  (REQ_SIZE == 2'd2 && REQ_ADDR[1:0] != 2'd0)) && (REQ_ADDR < IO_BASE);

      // Byte lane written in ST_BYTE; lane 0 is issued directly from IDLE.
      case (cnt_q)
         2'd0:    st_byte = wdata_q[7:0];
         2'd1:    st_byte = wdata_q[15:8];
         2'd2:    st_byte = wdata_q[23:16];
         default: st_byte = wdata_q[31:24];
      endcase
      last_cnt = word_q ? 2'd3 : 2'd1;

      window = {MEM_DOUT2, lo_q};
      win_sh = 32'(window >> {addr_q[1:0], 3'b000});

      case (state_q)
         IDLE: begin
            if (req_live && !crossing) begin
               MEM_ADDR2  = REQ_ADDR;
               MEM_DIN2   = REQ_WDATA;
               MEM_SIZE   = REQ_SIZE;
               MEM_SIGN   = REQ_SIGN;
               MEM_READ2  = !REQ_WE;
               MEM_WRITE2 = REQ_WE;
               pend_d     = !REQ_WE;
            end else if (req_live) begin
               addr_d  = REQ_ADDR;
               wdata_d = REQ_WDATA;
               word_d  = (REQ_SIZE == 2'd2);
               sign_d  = REQ_SIGN;
               STALL   = 1'b1;
               if (REQ_WE) begin
                  MEM_ADDR2  = REQ_ADDR;
                  MEM_DIN2   = {24'd0, REQ_WDATA[7:0]};
                  MEM_WRITE2 = 1'b1;
                  cnt_d      = 2'd1;
                  state_d    = ST_BYTE;
               end else begin
                  MEM_ADDR2 = {REQ_ADDR[31:2], 2'b00};
                  MEM_SIZE  = 2'd2;
                  MEM_READ2 = 1'b1;
                  state_d   = LD_HI;
               end
            end
         end
         LD_HI: begin
            MEM_ADDR2 = {addr_q[31:2] + 30'd1, 2'b00};
            MEM_SIZE  = 2'd2;
            MEM_READ2 = 1'b1;
            lo_d      = MEM_DOUT2;
            STALL     = 1'b1;
            state_d   = LD_FIN;
         end
         LD_FIN: begin
            state_d = IDLE;
         end
         ST_BYTE: begin
            MEM_ADDR2  = addr_q + {30'd0, cnt_q};
            MEM_DIN2   = {24'd0, st_byte};
            MEM_WRITE2 = 1'b1;
            STALL      = (cnt_q != last_cnt);
            if (cnt_q == last_cnt) begin
               cnt_d   = 2'd0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      RSP_VALID = pend_q || (state_q == LD_FIN);
      RSP_DATA  = 32'd0;
      if (state_q == LD_FIN) begin
         if (word_q)
            RSP_DATA = win_sh;
         else if (sign_q)
            RSP_DATA = {16'd0, win_sh[15:0]};
         else
            RSP_DATA = {{16{win_sh[15]}}, win_sh[15:0]};
      end else if (pend_q) begin
         RSP_DATA = MEM_DOUT2;
      end
   end

endmodule

// File: tb/tb_otter_lsu_split.sv
// Directed bench for otter_lsu_split with a byte-addressed memory model on data port 2.
module tb_otter_lsu_split;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic        REQ_VALID = 1'b0;
   logic        REQ_WE = 1'b0;
   logic [31:0] REQ_ADDR = 32'd0;
   logic [31:0] REQ_WDATA = 32'd0;
   logic [1:0]  REQ_SIZE = 2'd0;
   logic        REQ_SIGN = 1'b0;
   logic        STALL, RSP_VALID, MEM_READ2, MEM_WRITE2, MEM_SIGN;
   logic [31:0] RSP_DATA, MEM_ADDR2, MEM_DIN2;
   logic [1:0]  MEM_SIZE;
   logic [31:0] MEM_DOUT2 = 32'd0;

   int total = 0;
   int bad = 0;

   logic [7:0]  mem [0:1023];
   int          io_writes = 0;
   logic        bd_we = 1'b0;
   logic [9:0]  bd_addr = 10'd0;
   logic [31:0] bd_data = 32'd0;

   otter_lsu_split dut (
      .CLK(CLK), .RST_N(RST_N), .REQ_VALID(REQ_VALID), .REQ_WE(REQ_WE),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_SIZE(REQ_SIZE), .REQ_SIGN(REQ_SIGN),
      .STALL(STALL), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
      .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_READ2(MEM_READ2),
      .MEM_WRITE2(MEM_WRITE2), .MEM_SIZE(MEM_SIZE), .MEM_SIGN(MEM_SIGN), .MEM_DOUT2(MEM_DOUT2)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_rd(input logic [31:0] a, input logic [1:0] sz, input logic sg);
      logic [31:0] w;
      logic [9:0]  b;
      b = {a[9:2], 2'b00};
      w = {mem[b + 10'd3], mem[b + 10'd2], mem[b + 10'd1], mem[b]};
      w = w >> {a[1:0], 3'b000};
      case (sz)
         2'd0:    return sg ? {24'd0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
         2'd1:    return sg ? {16'd0, w[15:0]} : {{16{w[15]}}, w[15:0]};
         default: return w;
      endcase
   endfunction

   // Memory: synchronous read, byte-lane writes; IO writes are only counted.
   always @(posedge CLK) begin
      if (bd_we) begin
         for (int i = 0; i < 4; i++) mem[bd_addr + 10'(i)] <= bd_data[8*i +: 8];
      end else if (MEM_WRITE2) begin
         if (MEM_ADDR2 >= 32'h11000000) io_writes <= io_writes + 1;
         else begin
            mem[MEM_ADDR2[9:0]] <= MEM_DIN2[7:0];
            if (MEM_SIZE != 2'd0) mem[MEM_ADDR2[9:0] + 10'd1] <= MEM_DIN2[15:8];
            if (MEM_SIZE == 2'd2) begin
               mem[MEM_ADDR2[9:0] + 10'd2] <= MEM_DIN2[23:16];
               mem[MEM_ADDR2[9:0] + 10'd3] <= MEM_DIN2[31:24];
            end
         end
      end
      if (MEM_READ2)
         MEM_DOUT2 <= (MEM_ADDR2 >= 32'h11000000) ? 32'd0 : mem_rd(MEM_ADDR2, MEM_SIZE, MEM_SIGN);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic poke(input logic [9:0] a, input logic [31:0] d);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      next_cycle();
      bd_we = 1'b0;
   endtask

   task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic sg);
      REQ_VALID = 1'b1; REQ_WE = we; REQ_ADDR = a; REQ_WDATA = wd; REQ_SIZE = sz; REQ_SIGN = sg;
   endtask

   task automatic idle_req();
      REQ_VALID = 1'b0; REQ_WE = 1'b0; REQ_ADDR = 32'd0; REQ_WDATA = 32'd0; REQ_SIZE = 2'd0;
   endtask

   // Single aligned pass-through load; checks the response one cycle later.
   task automatic plain_lw(input string tag, input logic [31:0] a, input logic [31:0] exp);
      drive(1'b0, a, 32'd0, 2'd2, 1'b0);
      @(negedge CLK);
      check({tag, ".stall"}, {31'd0, STALL}, 32'd0);
      check({tag, ".rd"}, {31'd0, MEM_READ2}, 32'd1);
      check({tag, ".addr"}, MEM_ADDR2, a);
      next_cycle();
      idle_req();
      @(negedge CLK);
      check({tag, ".rvld"}, {31'd0, RSP_VALID}, 32'd1);
      check({tag, ".rdat"}, RSP_DATA, exp);
      next_cycle();
   endtask

   // Crossing load: REQ is held through the stall, as the pipeline would.
   task automatic split_ld(input string tag, input logic [31:0] a, input logic [1:0] sz,
                           input logic sg, input logic [31:0] exp);
      drive(1'b0, a, 32'd0, sz, sg);
      @(negedge CLK);
      check({tag, ".c0stall"}, {31'd0, STALL}, 32'd1);
      check({tag, ".c0addr"}, MEM_ADDR2, {a[31:2], 2'b00});
      check({tag, ".c0rd"}, {30'd0, MEM_READ2, MEM_WRITE2}, 32'd2);
      check({tag, ".c0size"}, {30'd0, MEM_SIZE}, 32'd2);
      next_cycle();
      @(negedge CLK);
      check({tag, ".c1stall"}, {31'd0, STALL}, 32'd1);
      check({tag, ".c1addr"}, MEM_ADDR2, {a[31:2], 2'b00} + 32'd4);
      check({tag, ".c1rvld"}, {31'd0, RSP_VALID}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check({tag, ".c2stall"}, {31'd0, STALL}, 32'd0);
      check({tag, ".c2rd"}, {31'd0, MEM_READ2}, 32'd0);
      check({tag, ".c2rvld"}, {31'd0, RSP_VALID}, 32'd1);
      check({tag, ".c2rdat"}, RSP_DATA, exp);
      next_cycle();
      idle_req();
   endtask

   initial begin
      logic [31:0] sw_data;
      sw_data = 32'hAABBCCDD;

      #2;
      @(negedge CLK);
      check("rst.stall", {31'd0, STALL}, 32'd0);
      check("rst.rvld", {31'd0, RSP_VALID}, 32'd0);
      check("rst.rdat", RSP_DATA, 32'd0);
      check("rst.rdwr", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
      next_cycle();
      RST_N = 1'b1;

      for (int i = 0; i < 256; i++) poke(10'(4 * i), 32'd0);
      poke(10'h100, 32'hDEADBEEF);
      plain_lw("lw100", 32'h100, 32'hDEADBEEF);

      poke(10'h100, 32'h80112233);
      poke(10'h104, 32'h445566F0);
      split_ld("lh103s", 32'h103, 2'd1, 1'b0, 32'hFFFFF080);
      split_ld("lh103u", 32'h103, 2'd1, 1'b1, 32'h0000F080);

      poke(10'h100, 32'h33221100);
      poke(10'h104, 32'h77665544);
      split_ld("lw102", 32'h102, 2'd2, 1'b0, 32'h55443322);

      // Word store crossing 0x200/0x204.
      drive(1'b1, 32'h201, sw_data, 2'd2, 1'b0);
      for (int k = 0; k < 4; k++) begin
         @(negedge CLK);
         check($sformatf("sw201.wr%0d", k), {30'd0, MEM_READ2, MEM_WRITE2}, 32'd1);
         check($sformatf("sw201.addr%0d", k), MEM_ADDR2, 32'h201 + 32'(k));
         check($sformatf("sw201.din%0d", k), MEM_DIN2, {24'd0, sw_data[8*k +: 8]});
         check($sformatf("sw201.size%0d", k), {30'd0, MEM_SIZE}, 32'd0);
         check($sformatf("sw201.stall%0d", k), {31'd0, STALL}, (k < 3) ? 32'd1 : 32'd0);
         next_cycle();
      end
      idle_req();
      plain_lw("sw201.lw200", 32'h200, 32'hBBCCDD00);
      plain_lw("sw201.lw204", 32'h204, 32'h000000AA);

      // Misaligned IO store is never split.
      drive(1'b1, 32'h11000002, 32'h12345678, 2'd2, 1'b0);
      @(negedge CLK);
      check("io.stall", {31'd0, STALL}, 32'd0);
      check("io.rdwr", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd1);
      check("io.size", {30'd0, MEM_SIZE}, 32'd2);
      check("io.addr", MEM_ADDR2, 32'h11000002);
      check("io.din", MEM_DIN2, 32'h12345678);
      next_cycle();
      idle_req();
      @(negedge CLK);
      check("io.after", {30'd0, MEM_WRITE2, STALL}, 32'd0);
      check("io.count", 32'(io_writes), 32'd1);
      next_cycle();

      // Reset in cycle 1 of a split store aborts after byte 0x201.
      poke(10'h200, 32'd0);
      poke(10'h204, 32'd0);
      drive(1'b1, 32'h201, sw_data, 2'd2, 1'b0);
      @(negedge CLK);
      check("abort.c0wr", {31'd0, MEM_WRITE2}, 32'd1);
      next_cycle();
      RST_N = 1'b0;
      idle_req();
      @(negedge CLK);
      check("abort.stall", {31'd0, STALL}, 32'd0);
      check("abort.rdwr", {30'd0, MEM_READ2, MEM_WRITE2}, 32'd0);
      check("abort.rvld", {31'd0, RSP_VALID}, 32'd0);
      check("abort.rdat", RSP_DATA, 32'd0);
      next_cycle();
      RST_N = 1'b1;
      next_cycle();
      plain_lw("abort.lw200", 32'h200, 32'h0000DD00);
      plain_lw("abort.lw204", 32'h204, 32'h00000000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
